// File: rtl/can_error_unit.sv
// CAN error detection (bit/stuff/form/CRC/ACK) with TEC/REC fault confinement
// and the active / passive / bus-off state machine including bus-off recovery.
module can_error_unit #(
   parameter int unsigned STUFF_LEN   = 5,
   parameter int unsigned CNT_W       = 9,
   parameter int unsigned PASSIVE_LIM = 128,
   parameter int unsigned BUSOFF_LIM  = 256,
   parameter int unsigned IDLE_BITS   = 11,
   parameter int unsigned RECOV_SEQS  = 128
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             SP,
   input  logic             RX,
   input  logic             TX,
   input  logic             tx_active,
   input  logic             F_STF,
   input  logic             F_ARB,
   input  logic             F_CRC_D,
   input  logic             F_ACK_D,
   input  logic             EOF_Flag,
   input  logic             F_ACK_SLOT,
   input  logic             crc_ok,
   input  logic             SOF,
   input  logic             frame_ok,
   output logic             ERROR,
   output logic [2:0]       err_code,
   output logic [CNT_W-1:0] tec,
   output logic [CNT_W-1:0] rec,
   output logic [1:0]       err_state
);

   localparam int unsigned RUN_W = $clog2(STUFF_LEN + 2);
   localparam int unsigned RC_W  = $clog2(IDLE_BITS + 1);
   localparam int unsigned SQ_W  = $clog2(RECOV_SEQS + 1);
   localparam int unsigned EXT_W = CNT_W + 1;

   localparam logic [RUN_W-1:0] L_RUN_MAX   = RUN_W'(STUFF_LEN + 1);
   localparam logic [RUN_W-1:0] L_RUN_LAST  = RUN_W'(STUFF_LEN);
   localparam logic [CNT_W-1:0] L_PASSIVE   = CNT_W'(PASSIVE_LIM);
   localparam logic [EXT_W-1:0] L_BUSOFF_X  = EXT_W'(BUSOFF_LIM);
   localparam logic [CNT_W-1:0] L_BUSOFF    = CNT_W'(BUSOFF_LIM);
   localparam logic [CNT_W-1:0] L_REC_RESET = CNT_W'(120);
   localparam logic [RC_W-1:0]  L_IDLE_LAST = RC_W'(IDLE_BITS - 1);
   localparam logic [SQ_W-1:0]  L_SEQ_LAST  = SQ_W'(RECOV_SEQS - 1);

   localparam logic [2:0] C_BIT   = 3'd1;
   localparam logic [2:0] C_STUFF = 3'd2;
   localparam logic [2:0] C_FORM  = 3'd3;
   localparam logic [2:0] C_CRC   = 3'd4;
   localparam logic [2:0] C_ACK   = 3'd5;

   typedef enum logic [1:0] {
      ST_ACTIVE  = 2'd0,
      ST_PASSIVE = 2'd1,
      ST_BUS_OFF = 2'd2
   } state_t;

   state_t           r_state, w_state_nxt;
   logic             r_error;
   logic [2:0]       r_code;
   logic [CNT_W-1:0] r_tec, r_rec;
   logic [CNT_W-1:0] w_tec_nxt, w_rec_nxt;
   logic             r_prev_rx;
   logic [RUN_W-1:0] r_run;
   logic [RUN_W-1:0] w_run_nxt;
   logic             r_mask;
   logic [RC_W-1:0]  r_rcnt;
   logic [SQ_W-1:0]  r_seq;

   logic             w_run_inc, w_stuff, w_bit, w_form, w_crc, w_ack;
   logic             w_det_en, w_err, w_rec_done, w_passive;
   logic [2:0]       w_code;
   logic [EXT_W-1:0] w_tec_add;

   // Violation detectors, evaluated on every sample point
   assign w_run_inc = F_STF && (RX == r_prev_rx);
   assign w_run_nxt = !w_run_inc ? RUN_W'(1) :
                      (r_run == L_RUN_MAX) ? r_run : r_run + RUN_W'(1);
   assign w_stuff   = w_run_inc && (r_run == L_RUN_LAST);
   assign w_bit     = tx_active && !F_ACK_SLOT && (RX != TX) && (!F_ARB || (!TX && RX));
   assign w_form    = !RX && (F_CRC_D || F_ACK_D || EOF_Flag);
   assign w_crc     = F_CRC_D && !crc_ok && !tx_active;
   assign w_ack     = tx_active && F_ACK_SLOT && RX;

   // SOF re-arms detection on the same sample point that it is seen
   assign w_det_en  = SP && (r_state != ST_BUS_OFF) && (!r_mask || SOF);
   assign w_err     = w_det_en && (w_bit || w_stuff || w_form || w_crc || w_ack);

   always_comb begin
      w_code = 3'd0;
      if (w_bit)        w_code = C_BIT;
      else if (w_stuff) w_code = C_STUFF;
      else if (w_form)  w_code = C_FORM;
      else if (w_crc)   w_code = C_CRC;
      else if (w_ack)   w_code = C_ACK;
   end

   assign w_rec_done = SP && (r_state == ST_BUS_OFF) && RX &&
                       (r_rcnt == L_IDLE_LAST) && (r_seq == L_SEQ_LAST);
   assign w_tec_add  = {1'b0, r_tec} + EXT_W'(8);

   // Next counter values: recovery, then error, then frame_ok
   always_comb begin
      w_tec_nxt = r_tec;
      w_rec_nxt = r_rec;
      if (w_rec_done) begin
         w_tec_nxt = '0;
         w_rec_nxt = '0;
      end else if (w_err) begin
         if (tx_active) begin
            w_tec_nxt = (w_tec_add >= L_BUSOFF_X) ? L_BUSOFF : w_tec_add[CNT_W-1:0];
         end else if (r_rec != {CNT_W{1'b1}}) begin
            w_rec_nxt = r_rec + CNT_W'(1);
         end
      end else if (frame_ok && (r_state != ST_BUS_OFF)) begin
         if (tx_active) begin
            if (r_tec != '0) w_tec_nxt = r_tec - CNT_W'(1);
         end else if (r_rec >= L_PASSIVE) begin
            w_rec_nxt = L_REC_RESET;
         end else if (r_rec != '0) begin
            w_rec_nxt = r_rec - CNT_W'(1);
         end
      end
   end

   assign w_passive = (w_tec_nxt >= L_PASSIVE) || (w_rec_nxt >= L_PASSIVE);

   // Fault-confinement state follows the counters on the same edge
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_ACTIVE, ST_PASSIVE: begin
            if (w_tec_nxt >= L_BUSOFF) w_state_nxt = ST_BUS_OFF;
            else if (w_passive)        w_state_nxt = ST_PASSIVE;
            else                       w_state_nxt = ST_ACTIVE;
         end
         ST_BUS_OFF: begin
            if (w_rec_done) w_state_nxt = ST_ACTIVE;
         end
         default: w_state_nxt = ST_ACTIVE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_ACTIVE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_error   <= 1'b0;
         r_code    <= 3'd0;
         r_tec     <= '0;
         r_rec     <= '0;
         r_prev_rx <= 1'b1;
         r_run     <= RUN_W'(1);
         r_mask    <= 1'b0;
      end else begin
         r_error <= w_err;
         r_tec   <= w_tec_nxt;
         r_rec   <= w_rec_nxt;
         if (w_err) r_code <= w_code;
         if (SP) begin
            r_prev_rx <= RX;
            r_run     <= w_run_nxt;
         end
         if (w_err)          r_mask <= 1'b1;
         else if (SP && SOF) r_mask <= 1'b0;
      end
   end

   // Bus-off recovery: runs of IDLE_BITS recessive samples, counted in sequences
   always_ff @(posedge clock) begin
      if (reset) begin
         r_rcnt <= '0;
         r_seq  <= '0;
      end else if (SP && (r_state == ST_BUS_OFF)) begin
         if (!RX) begin
            r_rcnt <= '0;
         end else if (r_rcnt == L_IDLE_LAST) begin
            r_rcnt <= '0;
            r_seq  <= w_rec_done ? '0 : r_seq + SQ_W'(1);
         end else begin
            r_rcnt <= r_rcnt + RC_W'(1);
         end
      end
   end

   assign ERROR     = r_error;
   assign err_code  = r_code;
   assign tec       = r_tec;
   assign rec       = r_rec;
   assign err_state = r_state;

endmodule

// File: tb/tb_can_error_unit.sv
// Scoreboard bench for can_error_unit: stimulus queues expected snapshots,
// a negedge monitor pops one per ERROR pulse and one per probe request.
module tb_can_error_unit;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       SP = 1'b0, RX = 1'b1, TX = 1'b1, tx_active = 1'b0;
   logic       F_STF = 1'b0, F_ARB = 1'b0, F_CRC_D = 1'b0, F_ACK_D = 1'b0;
   logic       EOF_Flag = 1'b0, F_ACK_SLOT = 1'b0, crc_ok = 1'b1;
   logic       SOF = 1'b0, frame_ok = 1'b0;
   logic       ERROR;
   logic [2:0] err_code;
   logic [8:0] tec, rec;
   logic [1:0] err_state;

   can_error_unit dut (
      .clock(clock), .reset(reset), .SP(SP), .RX(RX), .TX(TX),
      .tx_active(tx_active), .F_STF(F_STF), .F_ARB(F_ARB), .F_CRC_D(F_CRC_D),
      .F_ACK_D(F_ACK_D), .EOF_Flag(EOF_Flag), .F_ACK_SLOT(F_ACK_SLOT),
      .crc_ok(crc_ok), .SOF(SOF), .frame_ok(frame_ok), .ERROR(ERROR),
      .err_code(err_code), .tec(tec), .rec(rec), .err_state(err_state)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit         is_err;
      logic [2:0] code;
      logic [8:0] tec;
      logic [8:0] rec;
      logic [1:0] st;
      string      name;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic probe = 1'b0;

   task automatic check(input bit kind);
      exp_t e;
      n_cmp++;
      if (q.size() == 0) begin
         n_bad++;
         $display("FAIL unexpected_event: got err=%0b code=%0d tec=%0d rec=%0d st=%0d, no expectation queued",
                  kind, err_code, tec, rec, err_state);
         return;
      end
      e = q.pop_front();
      if (e.is_err != kind || err_code !== e.code || tec !== e.tec ||
          rec !== e.rec || err_state !== e.st) begin
         n_bad++;
         $display("FAIL %s: got err=%0b code=%0d tec=%0d rec=%0d st=%0d, want err=%0b code=%0d tec=%0d rec=%0d st=%0d",
                  e.name, kind, err_code, tec, rec, err_state,
                  e.is_err, e.code, e.tec, e.rec, e.st);
      end
   endtask

   // Monitor: an ERROR pulse consumes an error expectation, a probe a snapshot
   always @(negedge clock) begin
      if (ERROR === 1'b1) check(1'b1);
      if (probe)          check(1'b0);
   end

   task automatic push(input bit is_err, input int c, input int t, input int r,
                       input int s, input string nm);
      exp_t e;
      e.is_err = is_err;
      e.code   = 3'(c);
      e.tec    = 9'(t);
      e.rec    = 9'(r);
      e.st     = 2'(s);
      e.name   = nm;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      SP = 1'b0; SOF = 1'b0; frame_ok = 1'b0;
   endtask

   task automatic bit_sp(input logic rx, input logic tx);
      SP = 1'b1; RX = rx; TX = tx;
      tick();
   endtask

   task automatic sof();
      SOF = 1'b1;
      bit_sp(1'b0, 1'b0);
   endtask

   task automatic snap(input int c, input int t, input int r, input int s, input string nm);
      push(1'b0, c, t, r, s, nm);
      probe = 1'b1;
      @(posedge clock);
      #1;
      probe = 1'b0;
   endtask

   // Drive tec from 0 to 256 with 32 transmitter bit errors
   task automatic enter_busoff();
      tx_active = 1'b1;
      for (int i = 1; i <= 31; i++) begin
         sof();
         push(1'b1, 1, 8 * i, 0, (8 * i >= 128) ? 1 : 0, "bit_err_ramp");
         bit_sp(1'b0, 1'b1);
      end
      snap(1, 248, 0, 1, "tec_248_passive");
      sof();
      push(1'b1, 1, 256, 0, 2, "enter_bus_off");
      bit_sp(1'b0, 1'b1);
      sof();
      bit_sp(1'b0, 1'b1);
      frame_ok = 1'b1;
      tick();
      snap(1, 256, 0, 2, "bus_off_quiet");
      tx_active = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clock);
      #1;
      snap(0, 0, 0, 0, "reset_values");
      reset = 1'b0;
      tick();

      // Stuff error after six dominant samples, no second pulse on the 7th
      tx_active = 1'b0;
      F_STF = 1'b1;
      push(1'b1, 2, 0, 1, 0, "stuff_err");
      repeat (6) bit_sp(1'b0, 1'b1);
      bit_sp(1'b0, 1'b1);
      snap(2, 0, 1, 0, "stuff_masked");
      F_STF = 1'b0;

      frame_ok = 1'b1;
      tick();
      snap(2, 0, 0, 0, "rec_1_to_0");

      sof();
      F_CRC_D = 1'b1; crc_ok = 1'b0;
      push(1'b1, 4, 0, 1, 0, "crc_err");
      bit_sp(1'b1, 1'b1);
      F_CRC_D = 1'b0; crc_ok = 1'b1;
      snap(4, 0, 1, 0, "crc_code_holds");

      // Sixteen transmitter bit errors reach error-passive
      tx_active = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         sof();
         push(1'b1, 1, 8 * i, 1, (8 * i >= 128) ? 1 : 0, "bit_err");
         bit_sp(1'b0, 1'b1);
      end
      snap(1, 128, 1, 1, "tec_128_passive");
      frame_ok = 1'b1;
      tick();
      snap(1, 127, 1, 0, "tec_127_active");

      sof();
      F_ARB = 1'b1;
      bit_sp(1'b0, 1'b1);
      F_ARB = 1'b0;
      snap(1, 127, 1, 0, "arbitration_loss");

      sof();
      F_ACK_SLOT = 1'b1;
      push(1'b1, 5, 135, 1, 1, "ack_err");
      bit_sp(1'b1, 1'b1);
      F_ACK_SLOT = 1'b0;

      // Stuff, form and CRC violations on one sample point
      tx_active = 1'b0;
      sof();
      F_STF = 1'b1;
      bit_sp(1'b1, 1'b1);
      repeat (5) bit_sp(1'b0, 1'b1);
      F_CRC_D = 1'b1; crc_ok = 1'b0;
      push(1'b1, 2, 135, 2, 1, "priority_stuff");
      bit_sp(1'b0, 1'b1);
      F_CRC_D = 1'b0; crc_ok = 1'b1; F_STF = 1'b0;
      snap(2, 135, 2, 1, "single_pulse");

      for (int i = 1; i <= 128; i++) begin
         sof();
         EOF_Flag = 1'b1;
         push(1'b1, 3, 135, 2 + i, 1, "form_err");
         bit_sp(1'b0, 1'b1);
         EOF_Flag = 1'b0;
      end
      frame_ok = 1'b1;
      tick();
      snap(3, 135, 120, 1, "rec_130_to_120");

      reset = 1'b1;
      tick();
      snap(0, 0, 0, 0, "reset_mid_run");
      reset = 1'b0;
      enter_busoff();

      // Reset during recovery clears counters and recovery progress
      repeat (20) bit_sp(1'b1, 1'b1);
      reset = 1'b1;
      tick();
      snap(0, 0, 0, 0, "reset_in_bus_off");
      reset = 1'b0;
      enter_busoff();

      repeat (10) bit_sp(1'b1, 1'b1);
      bit_sp(1'b0, 1'b1);
      repeat (127 * 11) bit_sp(1'b1, 1'b1);
      snap(1, 256, 0, 2, "recovery_127_seqs");
      repeat (10) bit_sp(1'b1, 1'b1);
      snap(1, 256, 0, 2, "dominant_restarts_seq");
      bit_sp(1'b1, 1'b1);
      snap(1, 0, 0, 0, "recovered_active");

      repeat (2) tick();
      if (q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL leftover_expectations: got %0d pending, want 0 (first: %s)",
                  q.size(), q[0].name);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
